// File: rtl/pwm2throttle.sv
// Measures the high time of an RC/ESC PWM pulse in microseconds and decodes it back to an
// 8-bit throttle value (1064..1864 us span, <= IDLE_MAX_US idle), with loss-of-signal timeout.
module pwm2throttle #(
    parameter int unsigned CLK_MHZ      = 27,
    parameter int unsigned MIN_VALID_US = 800,
    parameter int unsigned MAX_VALID_US = 2200,
    parameter int unsigned IDLE_MAX_US  = 1000,
    parameter int unsigned TIMEOUT_MS   = 25
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [11:0] pulse_time,
    output logic [7:0]  throttle_setting,
    output logic        idle,
    output logic        valid,
    output logic        signal_lost
);

    localparam int unsigned TIMEOUT_US = TIMEOUT_MS * 1000;
    localparam int unsigned PW         = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam int unsigned TW         = $clog2(TIMEOUT_US + 1);
    localparam logic [11:0] SPAN_LO    = 12'd1064;
    localparam logic [11:0] SPAN_HI    = 12'd1864;
    localparam logic [9:0]  SPAN_W     = 10'd800;

    typedef enum logic [2:0] {
        WAIT_LOW,
        WAIT_RISE,
        MEASURE,
        CONV1,
        CONV2
    } state_t;

    state_t        state_q;
    logic          s1_q, s2_q, s3_q;
    logic          rise_q, fall_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [11:0]   width_q, width_d;
    logic [11:0]   meas_q;
    logic [9:0]    diff_q, diff_d;
    logic [31:0]   prod_d;
    logic [7:0]    thr_d;
    logic          us_tick;
    logic [PW-1:0] to_presc_q, to_presc_d;
    logic [TW-1:0] to_cnt_q;
    logic          to_tick, to_hit, to_sat;
    logic [11:0]   pt_q;
    logic [7:0]    thr_q;
    logic          idle_q, valid_q, lost_q;

    // Synchronizer is deliberately not reset so a pulse high across reset release stays high.
    always_ff @(posedge clock) begin
        s1_q <= pwm_in;
        s2_q <= s1_q;
        s3_q <= s2_q;
    end

    always_comb begin
        us_tick    = (presc_q == PW'(CLK_MHZ - 1));
        presc_d    = us_tick ? '0 : presc_q + PW'(1);
        width_d    = (us_tick && (width_q != '1)) ? width_q + 12'd1 : width_q;
        diff_d     = '0;
        if (meas_q >= SPAN_HI)
            diff_d = SPAN_W;
        else if (meas_q > SPAN_LO)
            diff_d = 10'(meas_q - SPAN_LO);
        prod_d     = 32'(diff_q) * 32'd20890 + 32'd32768;
        thr_d      = 8'(prod_d >> 16);
        to_tick    = (to_presc_q == PW'(CLK_MHZ - 1));
        to_presc_d = to_tick ? '0 : to_presc_q + PW'(1);
        to_sat     = (to_cnt_q == TW'(TIMEOUT_US));
        to_hit     = to_tick && (to_cnt_q == TW'(TIMEOUT_US - 1));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= WAIT_LOW;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            presc_q    <= '0;
            width_q    <= '0;
            meas_q     <= '0;
            diff_q     <= '0;
            to_presc_q <= '0;
            to_cnt_q   <= '0;
            pt_q       <= 12'd900;
            thr_q      <= '0;
            idle_q     <= 1'b1;
            valid_q    <= 1'b0;
            lost_q     <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            rise_q  <= s2_q & ~s3_q;
            fall_q  <= s3_q & ~s2_q;

            if (!to_sat) begin
                to_presc_q <= to_presc_d;
                if (to_tick)
                    to_cnt_q <= to_cnt_q + TW'(1);
                if (to_hit) begin
                    lost_q <= 1'b1;
                    idle_q <= 1'b1;
                    thr_q  <= '0;
                end
            end

            case (state_q)
                WAIT_LOW: begin
                    if (!s2_q)
                        state_q <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise_q) begin
                        presc_q <= '0;
                        width_q <= '0;
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    presc_q <= presc_d;
                    width_q <= width_d;
                    // The tick of the falling-edge cycle counts, so the latched width is width_d.
                    if (fall_q) begin
                        if ((width_d >= 12'(MIN_VALID_US)) && (width_d <= 12'(MAX_VALID_US))) begin
                            meas_q  <= width_d;
                            state_q <= CONV1;
                        end else begin
                            state_q <= WAIT_RISE;
                        end
                    end
                end
                CONV1: begin
                    diff_q  <= diff_d;
                    state_q <= CONV2;
                end
                CONV2: begin
                    // Placed after the timeout update so a coincident valid overrides it.
                    pt_q       <= meas_q;
                    idle_q     <= (meas_q <= 12'(IDLE_MAX_US));
                    thr_q      <= (meas_q <= 12'(IDLE_MAX_US)) ? '0 : thr_d;
                    lost_q     <= 1'b0;
                    valid_q    <= 1'b1;
                    to_cnt_q   <= '0;
                    to_presc_q <= '0;
                    state_q    <= WAIT_RISE;
                end
                default: state_q <= WAIT_LOW;
            endcase
        end
    end

    assign pulse_time       = pt_q;
    assign throttle_setting = thr_q;
    assign idle             = idle_q;
    assign valid            = valid_q;
    assign signal_lost      = lost_q;

endmodule

// File: tb/tb_pwm2throttle.sv
// Randomized and directed pulse stimulus for pwm2throttle, checked against a behavioural model
// (scaled clock and timeout so the run stays short).
module tb_pwm2throttle;

    localparam int CLK_MHZ    = 2;
    localparam int TIMEOUT_MS = 4;
    localparam int TIMEOUT_US = TIMEOUT_MS * 1000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pwm_in = 1'b0;
    logic [11:0] pulse_time;
    logic [7:0]  throttle_setting;
    logic        idle;
    logic        valid;
    logic        signal_lost;

    int checks = 0;
    int errors = 0;

    int exp_pt   = 900;
    int exp_thr  = 0;
    int exp_idle = 1;
    int exp_lost = 1;

    always #5 clock = ~clock;

    pwm2throttle #(
        .CLK_MHZ     (CLK_MHZ),
        .MIN_VALID_US(800),
        .MAX_VALID_US(2200),
        .IDLE_MAX_US (1000),
        .TIMEOUT_MS  (TIMEOUT_MS)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pwm_in          (pwm_in),
        .pulse_time      (pulse_time),
        .throttle_setting(throttle_setting),
        .idle            (idle),
        .valid           (valid),
        .signal_lost     (signal_lost)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Throttle as the receiver should decode it from a pulse width in microseconds.
    function automatic int model_thr(input int w);
        int d;
        if (w <= 1000) return 0;
        d = w - 1064;
        if (d < 0)   d = 0;
        if (d > 800) d = 800;
        return (d * 20890 + 32768) / 65536;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".pulse_time"}, int'(pulse_time), exp_pt);
        check({tag, ".throttle"}, int'(throttle_setting), exp_thr);
        check({tag, ".idle"}, int'(idle), exp_idle);
        check({tag, ".lost"}, int'(signal_lost), exp_lost);
    endtask

    // Watches 8 cycles after the falling edge has been driven; valid must appear once,
    // at the 6th sampled edge (5 clocks after the first edge sampling low), or not at all.
    task automatic watch(input bit accept, input int us, input string tag);
        int nval = 0;
        int vidx = 0;
        int cpt = 0, cthr = 0, cidle = 0, clost = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock);
            #1;
            if (valid) begin
                nval++;
                vidx  = k;
                cpt   = int'(pulse_time);
                cthr  = int'(throttle_setting);
                cidle = int'(idle);
                clost = int'(signal_lost);
            end
        end
        if (accept) begin
            exp_pt   = us;
            exp_thr  = model_thr(us);
            exp_idle = (us <= 1000) ? 1 : 0;
            exp_lost = 0;
            check({tag, ".nvalid"}, nval, 1);
            check({tag, ".latency"}, vidx, 6);
            check({tag, ".v_pt"}, cpt, exp_pt);
            check({tag, ".v_thr"}, cthr, exp_thr);
            check({tag, ".v_idle"}, cidle, exp_idle);
            check({tag, ".v_lost"}, clost, exp_lost);
        end else begin
            check({tag, ".nvalid"}, nval, 0);
        end
        check_outputs(tag);
    endtask

    task automatic send(input int us, input int extra, input int gap_us, input string tag);
        @(posedge clock);
        #1 pwm_in = 1'b1;
        repeat (us * CLK_MHZ + extra) @(posedge clock);
        #1 pwm_in = 1'b0;
        watch((us >= 800) && (us <= 2200), us, tag);
        repeat (gap_us * CLK_MHZ) @(posedge clock);
    endtask

    initial begin
        #1200000;
        $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        int  w;
        bit  prev_disc;

        repeat (3) @(posedge clock);
        #1;
        check_outputs("reset");
        check("reset.valid", int'(valid), 0);
        @(negedge clock) reset = 1'b1;
        repeat (20) @(posedge clock);

        send(1500, 0, 50, "p1500");
        send(900, 1, 50, "p900");
        send(1064, 0, 50, "p1064");
        send(1864, 1, 50, "p1864");
        send(2000, 0, 50, "p2000");
        send(300, 1, 50, "glitch300");
        send(2500, 0, 50, "long2500");
        send(1030, 1, 50, "p1030");
        send(1000, 0, 50, "p1000");
        send(800, 1, 50, "p800");

        send(1500, 0, 0, "pre_timeout");
        repeat (TIMEOUT_US * CLK_MHZ - 40) @(posedge clock);
        #1;
        check("before_timeout.lost", int'(signal_lost), 0);
        repeat (80) @(posedge clock);
        #1;
        exp_lost = 1;
        exp_idle = 1;
        exp_thr  = 0;
        check_outputs("timeout");
        send(1200, 0, 50, "p1200");

        @(posedge clock);
        #1 pwm_in = 1'b1;
        repeat (400 * CLK_MHZ) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        exp_pt   = 900;
        exp_thr  = 0;
        exp_idle = 1;
        exp_lost = 1;
        check_outputs("midreset");
        check("midreset.valid", int'(valid), 0);
        reset = 1'b1;
        repeat (1000 * CLK_MHZ) @(posedge clock);
        #1 pwm_in = 1'b0;
        watch(1'b0, 0, "partial");
        repeat (50 * CLK_MHZ) @(posedge clock);
        send(1300, 0, 50, "p1300");

        prev_disc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (!prev_disc && ($urandom_range(0, 3) == 0)) begin
                w = ($urandom_range(0, 1) == 0) ? int'($urandom_range(100, 790))
                                                : int'($urandom_range(2201, 2600));
                prev_disc = 1'b1;
            end else begin
                w = int'($urandom_range(800, 2200));
                prev_disc = 1'b0;
            end
            send(w, int'($urandom_range(0, CLK_MHZ - 1)), int'($urandom_range(20, 100)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
